udp_payload_packer: RTL and testbench

- Sits directly upstream of the UDP packet sender.
- Buffers the acquisition sample stream into an internal FIFO.
- When one full UDP payload is buffered, it pulses the sender's sync and streams out one header word followed by payload words on a valid/ready interface.
- It also drives the payload length input of the sender, latched per packet.

---
 rtl/udp_payload_packer_pkg.sv | 43 ++++
 rtl/udp_payload_packer_fifo.sv | 81 ++++++++
 rtl/udp_payload_packer.sv | 200 ++++++++++++++++++++
 tb/tb_udp_payload_packer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_payload_packer_pkg.sv
// ---------------------------------------------------------------------------
// udp_payload_packer_pkg
//   Shared definitions for the UDP payload packer:
//   - packer FSM state encoding
//   - header word field layout
//   - payload length validity check
// ---------------------------------------------------------------------------
package udp_payload_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // buffering, waiting for a full payload
        ST_WAIT   = 2'd1,   // first word presented, waiting for sender
        ST_STREAM = 2'd2    // streaming the remaining payload words
    } state_e;

    // Header word layout: {seq[15:0], words[15:0]}
    localparam int HDR_SEQ_LSB   = 16;
    localparam int HDR_WORDS_LSB = 0;
    localparam int HDR_FIELD_W   = 16;

    // A length is usable when it is word aligned, covers at least two words,
    // and the FIFO-sourced part of the packet fits in the FIFO.
    function automatic logic len_valid(input logic [15:0] pkt_len,
                                       input int unsigned depth_log2,
                                       input logic        hdr_en);
        logic [13:0] words;
        int unsigned fifo_words;
        words      = pkt_len[15:2];
        fifo_words = 32'(words) - 32'(hdr_en);
        return (pkt_len[1:0] == 2'b00) && (words >= 14'd2) &&
               (fifo_words <= (32'd1 << depth_log2));
    endfunction

    function automatic logic [31:0] make_header(input logic [HDR_FIELD_W-1:0] seq,
                                                input logic [HDR_FIELD_W-1:0] words);
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_SEQ_LSB   +: HDR_FIELD_W] = seq;
        hdr[HDR_WORDS_LSB +: HDR_FIELD_W] = words;
        return hdr;
    endfunction

endpackage

// File: rtl/udp_payload_packer_fifo.sv
// ---------------------------------------------------------------------------
// udp_pkt_fifo
//   Synchronous show-ahead FIFO, 32-bit wide, 2^DEPTH_LOG2 entries.
//   rd_data_o always shows the head entry; rd_en_i pops it.
//
//   clk        in   clock
//   rst        in   asynchronous reset, active-high (empties the FIFO)
//   flush_i    in   synchronous empty, wins over read/write
//   wr_en_i    in   push wr_data_i (ignored when full)
//   wr_data_i  in   write data
//   rd_en_i    in   pop head entry (ignored when empty)
//   rd_data_o  out  head entry (show-ahead)
//   count_o    out  number of stored entries
//   full_o     out  FIFO full
//   empty_o    out  FIFO empty
// ---------------------------------------------------------------------------
module udp_pkt_fifo #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [31:0]           wr_data_i,
    input  logic                  rd_en_i,
    output logic [31:0]           rd_data_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_wr;
    logic                  do_rd;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_wr   = wr_en_i & ~full_o  & ~flush_i;
    assign do_rd   = rd_en_i & ~empty_o & ~flush_i;

    // NOTE: the storage array is deliberately not reset; emptiness is defined
    // by the pointers and count, so clearing them is enough and keeps the
    // array mappable to RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (DEPTH_LOG2+1)'(1);
                2'b01:   count_q <= count_q - (DEPTH_LOG2+1)'(1);
                default: count_q <= count_q;   // idle, or push+pop balance
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/udp_payload_packer.sv
// ---------------------------------------------------------------------------
// udp_payload_packer
//   Buffers acquisition samples and, once a full UDP payload is held, pulses
//   the sender's sync and streams {header?, payload...} on valid/ready.
//
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   i_enable       in   packing enable (0: discard input, flush FIFO in IDLE)
//   i_pkt_len      in   payload length in bytes, header word included
//   i_smp_data     in   sample word
//   i_smp_vld      in   sample valid
//   o_smp_rdy      out  sample ready
//   o_sync         out  one-cycle packet request to sender
//   o_udp_pkt_len  out  payload length latched for the current packet
//   o_out_data     out  payload word to sender
//   o_out_vld      out  payload valid
//   i_out_rdy      in   sender ready
//   o_seq          out  sequence number of the last issued packet
//   o_drop_cnt     out  samples discarded while disabled (saturating)
//   o_len_err      out  i_pkt_len sampled in IDLE is invalid
// ---------------------------------------------------------------------------
module udp_payload_packer
    import udp_payload_packer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int SYNC_TMO   = 4096,
    parameter int HDR_EN     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [15:0] i_pkt_len,
    input  logic [31:0] i_smp_data,
    input  logic        i_smp_vld,
    output logic        o_smp_rdy,
    output logic        o_sync,
    output logic [15:0] o_udp_pkt_len,
    output logic [31:0] o_out_data,
    output logic        o_out_vld,
    input  logic        i_out_rdy,
    output logic [15:0] o_seq,
    output logic [15:0] o_drop_cnt,
    output logic        o_len_err
);

    localparam logic HDR   = (HDR_EN != 0);
    localparam int   TMR_W = $clog2(SYNC_TMO + 1);

    state_e             state_q, state_d;
    logic [15:0]        seq_q, seq_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               sync_q, sync_d;
    logic [15:0]        pkt_len_q, pkt_len_d;
    logic               len_err_q, len_err_d;
    logic [13:0]        words_q, words_d;
    logic [13:0]        rem_q, rem_d;

    logic [31:0]         fifo_rd_data;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_wr;
    logic                fifo_rd;
    logic                fifo_flush;

    logic [13:0] words_in;
    logic        len_ok;
    logic        fill_ok;
    logic        xfer_out;

    assign words_in = i_pkt_len[15:2];
    assign len_ok   = len_valid(i_pkt_len, DEPTH_LOG2, HDR);
    // Compare count + HDR against words to avoid an unsigned underflow.
    assign fill_ok  = len_ok && ((32'(fifo_count) + 32'(HDR)) >= 32'(words_in));

    assign o_out_vld = (state_q != ST_IDLE);
    assign xfer_out  = o_out_vld & i_out_rdy;

    // While disabled outside IDLE the input stalls; once back in IDLE the
    // pending samples are accepted and discarded.
    assign o_smp_rdy  = i_enable ? ~fifo_full : (state_q == ST_IDLE);
    assign fifo_wr    = i_enable & i_smp_vld & o_smp_rdy;
    assign fifo_flush = (state_q == ST_IDLE) & ~i_enable;
    // The header word in WAIT comes from the register file, not the FIFO.
    assign fifo_rd    = xfer_out & ~fifo_empty &
                        ((state_q == ST_STREAM) | ((state_q == ST_WAIT) & ~HDR));

    always_comb begin
        o_out_data = 32'd0;
        if (state_q == ST_WAIT && HDR) begin
            o_out_data = make_header(seq_q, {2'b00, words_q});
        end else if (state_q != ST_IDLE) begin
            o_out_data = fifo_rd_data;
        end
    end

    udp_pkt_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (fifo_flush),
        .wr_en_i    (fifo_wr),
        .wr_data_i  (i_smp_data),
        .rd_en_i    (fifo_rd),
        .rd_data_o  (fifo_rd_data),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        drop_cnt_d = drop_cnt_q;
        timer_d    = timer_q;
        sync_d     = 1'b0;
        pkt_len_d  = pkt_len_q;
        len_err_d  = len_err_q;
        words_d    = words_q;
        rem_d      = rem_q;

        case (state_q)
            ST_IDLE: begin
                timer_d   = '0;
                len_err_d = ~len_ok;
                if (!i_enable) begin
                    if (i_smp_vld && drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end else if (fill_ok) begin
                    words_d   = words_in;
                    pkt_len_d = i_pkt_len;
                    seq_d     = seq_q + 16'd1;
                    sync_d    = 1'b1;
                    state_d   = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (xfer_out) begin
                    rem_d   = words_q - 14'd1;
                    timer_d = '0;
                    state_d = ST_STREAM;
                end else if (timer_q == TMR_W'(SYNC_TMO - 1)) begin
                    // Sender never answered: ask again for the same packet.
                    sync_d  = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_STREAM: begin
                if (xfer_out) begin
                    rem_d = rem_q - 14'd1;
                    if (rem_q == 14'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            timer_q    <= '0;
            sync_q     <= 1'b0;
            pkt_len_q  <= '0;
            len_err_q  <= 1'b0;
            words_q    <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            timer_q    <= timer_d;
            sync_q     <= sync_d;
            pkt_len_q  <= pkt_len_d;
            len_err_q  <= len_err_d;
            words_q    <= words_d;
            rem_q      <= rem_d;
        end
    end

    assign o_sync        = sync_q;
    assign o_udp_pkt_len = pkt_len_q;
    assign o_seq         = seq_q;
    assign o_drop_cnt    = drop_cnt_q;
    assign o_len_err     = len_err_q;

endmodule

// File: tb/tb_udp_payload_packer.sv
// ---------------------------------------------------------------------------
// tb_udp_payload_packer
//   Scoreboard bench: stimulus pushes the expected output words into exp_q,
//   an independent monitor pops and compares on every output transfer and
//   checks each o_sync pulse.
// ---------------------------------------------------------------------------
module tb_udp_payload_packer;

    localparam int DEPTH_LOG2 = 10;
    localparam int SYNC_TMO   = 4096;
    localparam int HDR_EN     = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b1;
    logic [15:0] i_pkt_len = 16'd16;
    logic [31:0] i_smp_data = '0;
    logic        i_smp_vld = 1'b0;
    logic        o_smp_rdy;
    logic        o_sync;
    logic [15:0] o_udp_pkt_len;
    logic [31:0] o_out_data;
    logic        o_out_vld;
    logic        i_out_rdy = 1'b0;
    logic [15:0] o_seq;
    logic [15:0] o_drop_cnt;
    logic        o_len_err;

    always #5 clk = ~clk;

    udp_payload_packer #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .SYNC_TMO   (SYNC_TMO),
        .HDR_EN     (HDR_EN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (i_enable),
        .i_pkt_len     (i_pkt_len),
        .i_smp_data    (i_smp_data),
        .i_smp_vld     (i_smp_vld),
        .o_smp_rdy     (o_smp_rdy),
        .o_sync        (o_sync),
        .o_udp_pkt_len (o_udp_pkt_len),
        .o_out_data    (o_out_data),
        .o_out_vld     (o_out_vld),
        .i_out_rdy     (i_out_rdy),
        .o_seq         (o_seq),
        .o_drop_cnt    (o_drop_cnt),
        .o_len_err     (o_len_err)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] smp_q[$];
    int          sync_cyc_q[$];
    int          cyc = 0;
    int          n_out = 0;
    int          sync_cnt = 0;
    int          last_acc_cyc = 0;
    logic [15:0] seq_m = '0;
    logic [15:0] exp_len = '0;
    logic        prev_vld = 1'b0;
    logic        prev_rdy = 1'b0;
    logic        prev_sync = 1'b0;
    logic [31:0] prev_data = '0;
    bit          sender_done;
    bit          stop_rnd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every output transfer and every sync pulse.
    always @(negedge clk) begin
        if (rst) begin
            prev_vld  <= 1'b0;
            prev_sync <= 1'b0;
        end else begin
            if (prev_vld && !prev_rdy) begin
                check("out_vld_hold", o_out_vld, 1);
                check("out_data_hold", o_out_data, prev_data);
            end
            if (o_out_vld && i_out_rdy) begin
                if (exp_q.size() == 0) fail_now("out_unexpected", $sformatf("got 0x%08h, expected no word", o_out_data));
                else check("out_word", o_out_data, exp_q.pop_front());
                n_out++;
            end
            if (o_sync) begin
                sync_cnt++;
                sync_cyc_q.push_back(cyc);
                check("sync_one_cycle", prev_sync, 0);
                check("sync_with_vld", o_out_vld, 1);
                check("sync_seq", o_seq, seq_m);
                check("sync_pkt_len", o_udp_pkt_len, exp_len);
            end
            prev_vld  <= o_out_vld;
            prev_rdy  <= i_out_rdy;
            prev_data <= o_out_data;
            prev_sync <= o_sync;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        bit acc = 1'b0;
        i_smp_data = d;
        i_smp_vld  = 1'b1;
        for (int n = 0; n < 10000 && !acc; n++) begin
            @(negedge clk);
            acc = o_smp_rdy;
        end
        @(posedge clk);
        #1;
        i_smp_vld = 1'b0;
        if (!acc) fail_now("send_timeout", $sformatf("sample 0x%08h never accepted", d));
        else begin
            last_acc_cyc = cyc;
            if (i_enable) smp_q.push_back(d);
        end
    endtask

    // Expected packet: header {seq, words} then words-1 buffered samples.
    task automatic expect_pkt(input logic [15:0] len);
        int words = int'(len[15:2]);
        seq_m   = seq_m + 16'd1;
        exp_len = len;
        exp_q.push_back({seq_m, 16'(words)});
        for (int i = 1; i < words; i++) begin
            if (smp_q.size() == 0) begin
                fail_now("model_underflow", "not enough samples buffered");
                break;
            end
            exp_q.push_back(smp_q.pop_front());
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int n = 0; n < budget && exp_q.size() != 0; n++) @(posedge clk);
        wait_cycles(2);
        check({name, "_drained"}, exp_q.size(), 0);
        @(negedge clk);
        check({name, "_idle_vld"}, o_out_vld, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = o_out_vld;
        end
        if (!seen) fail_now(name, "o_out_vld never rose");
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        i_enable   = 1'b1;
        i_pkt_len  = 16'd16;
        i_smp_vld  = 1'b0;
        i_smp_data = '0;
        i_out_rdy  = 1'b0;
        exp_q.delete();
        smp_q.delete();
        seq_m   = '0;
        exp_len = '0;
        wait_cycles(2);
        check("rst_out_vld", o_out_vld, 0);
        check("rst_sync", o_sync, 0);
        check("rst_seq", o_seq, 0);
        check("rst_drop_cnt", o_drop_cnt, 0);
        check("rst_pkt_len", o_udp_pkt_len, 0);
        check("rst_len_err", o_len_err, 0);
        rst = 1'b0;
        wait_cycles(1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int o0;
        int lens[3] = '{14, 4, 4104};

        // 1: len 16, three samples, sender always ready.
        do_reset();
        i_out_rdy = 1'b1;
        s0 = sync_cnt; o0 = n_out; sync_cyc_q.delete();
        send(32'hA000_0001); send(32'hB000_0002); send(32'hC000_0003);
        expect_pkt(16);
        wait_drain("s1", 100);
        check("s1_sync_cnt", sync_cnt - s0, 1);
        if (sync_cyc_q.size() > 0) check("s1_sync_latency", sync_cyc_q[0] - last_acc_cyc, 1);
        check("s1_out_cnt", n_out - o0, 4);
        check("s1_pkt_len", o_udp_pkt_len, 16);

        // 2: two samples are not enough; the third starts the packet.
        do_reset();
        i_out_rdy = 1'b1;
        s0 = sync_cnt; o0 = n_out;
        send(32'h2000_0001); send(32'h2000_0002);
        wait_cycles(10);
        check("s2_no_sync", sync_cnt - s0, 0);
        check("s2_no_vld", o_out_vld, 0);
        send(32'h2000_0003);
        expect_pkt(16);
        wait_drain("s2", 100);
        check("s2_sync_cnt", sync_cnt - s0, 1);
        check("s2_out_cnt", n_out - o0, 4);

        // 3: sender stalls; o_sync repeats every SYNC_TMO cycles.
        do_reset();
        s0 = sync_cnt; o0 = n_out; sync_cyc_q.delete();
        send(32'h3000_0001); send(32'h3000_0002); send(32'h3000_0003);
        expect_pkt(16);
        wait_cycles(2 * SYNC_TMO + 10);
        check("s3_sync_cnt", sync_cnt - s0, 3);
        if (sync_cyc_q.size() >= 3) begin
            check("s3_retry1", sync_cyc_q[1] - sync_cyc_q[0], SYNC_TMO);
            check("s3_retry2", sync_cyc_q[2] - sync_cyc_q[0], 2 * SYNC_TMO);
        end
        check("s3_seq_fixed", o_seq, 16'd1);
        i_out_rdy = 1'b1;
        wait_drain("s3", 100);
        check("s3_out_cnt", n_out - o0, 4);

        // 4: invalid lengths; 4100 is the largest valid one for 1024 words.
        s0 = sync_cnt;
        foreach (lens[k]) begin
            i_pkt_len = 16'(lens[k]);
            wait_cycles(3);
            check($sformatf("s4_len_err_%0d", lens[k]), o_len_err, 1);
        end
        check("s4_no_sync", sync_cnt - s0, 0);
        i_pkt_len = 16'd4100;
        wait_cycles(3);
        check("s4_len_4100_ok", o_len_err, 0);
        i_pkt_len = 16'd8;
        wait_cycles(3);
        check("s4_len_8_ok", o_len_err, 0);
        send(32'h4000_0001);
        expect_pkt(8);
        wait_drain("s4", 100);
        check("s4_sync_cnt", sync_cnt - s0, 1);

        // 5: fill to full with the sender stalled, then drain at random.
        s0 = sync_cnt; o0 = n_out;
        i_out_rdy   = 1'b0;
        i_pkt_len   = 16'd8192;
        sender_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1100; i++) send(32'h5000_0000 + i);
                sender_done = 1'b1;
            end
        join_none
        for (int n = 0; n < 3000 && smp_q.size() < 1024; n++) @(posedge clk);
        wait_cycles(10);
        check("s5_fill_level", smp_q.size(), 1024);
        @(negedge clk);
        check("s5_rdy_when_full", o_smp_rdy, 0);
        check("s5_len_err", o_len_err, 1);
        check("s5_no_sync", sync_cnt - s0, 0);
        @(posedge clk);
        #1;
        expect_pkt(4100);
        i_pkt_len = 16'd4100;
        stop_rnd  = 1'b0;
        fork
            begin
                while (!stop_rnd) begin
                    @(posedge clk);
                    #1;
                    if (!stop_rnd) i_out_rdy = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int n = 0; n < 20000 && !sender_done; n++) @(posedge clk);
        #1;
        if (!sender_done) fail_now("s5_sender", "input stream never completed");
        expect_pkt(308);
        i_pkt_len = 16'd308;
        wait_drain("s5", 20000);
        stop_rnd = 1'b1;
        wait_cycles(1);
        #1;
        i_out_rdy = 1'b1;
        check("s5_out_cnt", n_out - o0, 1102);
        check("s5_sync_cnt", sync_cnt - s0, 2);

        // 6: disable mid-STREAM; packet completes, leftover flushed, drops counted.
        i_out_rdy = 1'b0;
        i_pkt_len = 16'd16;
        send(32'h6000_000A); send(32'h6000_000B); send(32'h6000_000C); send(32'h6000_000D);
        expect_pkt(16);
        wait_vld("s6_vld");
        @(posedge clk); #1;
        i_out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_out_rdy = 1'b0;
        i_enable  = 1'b0;
        wait_cycles(3);
        @(negedge clk);
        check("s6_mid_pkt_vld", o_out_vld, 1);
        @(posedge clk); #1;
        i_out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) send(32'h6100_0000 + i);
        wait_drain("s6", 100);
        check("s6_drop_cnt", o_drop_cnt, 5);
        smp_q.delete();
        i_enable  = 1'b1;
        i_pkt_len = 16'd8;
        send(32'h6000_000E);
        expect_pkt(8);
        wait_drain("s6_after_flush", 100);

        // Reset in the middle of a packet.
        i_out_rdy = 1'b0;
        i_pkt_len = 16'd16;
        send(32'h7000_0001); send(32'h7000_0002); send(32'h7000_0003);
        expect_pkt(16);
        wait_vld("s7_vld");
        @(posedge clk); #1;
        i_out_rdy = 1'b1;
        @(posedge clk); #1;
        i_out_rdy = 1'b0;
        #1;
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("s7_rst_vld", o_out_vld, 0);
        check("s7_rst_seq", o_seq, 0);
        check("s7_rst_sync", o_sync, 0);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
